// File: rtl/multicycle_control.sv
// Control unit for a multicycle RV32I subset core: lw, sw, R-type, I-type ALU,
// jal, beq. A Moore FSM steps each instruction through its datapath phases.
// The per-state control word is registered alongside the state register, so
// every control output apart from the live decodes comes straight from a flop.
// PCWrite also depends combinationally on Zero for beq. ALUControl and ImmSrc
// are decoded live from the instruction fields.
// While RST is low the FSM sits in FETCH and all write enables are held at 0.
//
// Build option: define ILLEGAL_TRAP_EN to send unrecognised opcodes to a
// sticky TRAP state that raises Illegal and only leaves on reset. Without it,
// unrecognised opcodes act as a two-cycle NOP and Illegal is tied to 0.
// State is the debug view of the FSM.
module multicycle_control (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State,
  output logic       Illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Control word held in flops next to the state register.
  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  // Moore output table: the control word that goes with each state.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.pcupdate  = 1'b1;
      end
      S_DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      S_MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      S_MEMREAD: c.adrsrc = 1'b1;
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b00;
        c.aluop   = 2'b10;
      end
      S_ALUWB: c.regwrite = 1'b1;
      S_EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      S_JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b00;
        c.branch  = 1'b1;
        c.aluop   = 2'b01;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection from the current state and the opcode.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      state_nxt = S_TRAP;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_nxt = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_JAL:      state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_nxt = S_TRAP;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

  // State register plus its registered control word; reset lands in FETCH.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_FETCH;
      ctrl  <= ctrl_for(S_FETCH);
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_for(state_nxt);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;

  // Illegal flag follows entry into TRAP; reset clears it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) illegal_r <= 1'b0;
    else      illegal_r <= (state_nxt == S_TRAP);
  end

  assign Illegal = illegal_r;
`else
  assign Illegal = 1'b0;
`endif

  // ALU operation from ALUOp and the function fields.
  always_comb begin
    ALUControl = 3'b000;
    case (ctrl.aluop)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (Funct3)
          3'b000:  ALUControl = (Op[5] & Funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format straight from the opcode, in every state.
  always_comb begin
    ImmSrc = 2'b00;
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are held low for as long as reset is asserted.
  assign PCWrite   = RST & (ctrl.pcupdate | (ctrl.branch & Zero));
  assign MemWrite  = RST & ctrl.memwrite;
  assign IRWrite   = RST & ctrl.irwrite;
  assign RegWrite  = RST & ctrl.regwrite;
  assign AdrSrc    = ctrl.adrsrc;
  assign ResultSrc = ctrl.resultsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign State     = state;

endmodule
